// File: rtl/delay_timer_pkg.sv
// delay_timer_pkg: shared types and defaults for the programmable delay timer.
// Optional feature macro: DELAY_TIMER_PRESCALE_EN (see delay_timer.sv).
package delay_timer_pkg;

    localparam int DEF_WIDTH    = 8;
    localparam int DEF_PRESCALE = 50000;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COUNTING = 2'd1,
        EXPIRED  = 2'd2
    } state_t;

    // Prescaler counter width; never zero so PRESCALE=1 still yields a legal vector.
    function automatic int prescale_w(input int prescale);
        int w;
        w = $clog2(prescale);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/delay_timer_if.sv
// delay_timer_if: delay handshake between the control FSM (master) and the timer (slave).
interface delay_timer_if
    import delay_timer_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic             start_delay_counter;
    logic             enable_delay_counter;
    logic [WIDTH-1:0] delay_value;
    logic             delay_done;
    logic             busy;
    logic [WIDTH-1:0] count_remaining;

    modport master (
        output start_delay_counter, enable_delay_counter, delay_value,
        input  delay_done, busy, count_remaining
    );

    modport slave (
        input  start_delay_counter, enable_delay_counter, delay_value,
        output delay_done, busy, count_remaining
    );
endinterface

// File: rtl/delay_prescaler.sv
// delay_prescaler: divides enabled clk cycles into delay units of PRESCALE cycles.
// Used only when DELAY_TIMER_PRESCALE_EN is defined.
module delay_prescaler
    import delay_timer_pkg::*;
#(
    parameter int PRESCALE = DEF_PRESCALE
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic run,
    output logic tick
);
    localparam int            PW   = prescale_w(PRESCALE);
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] pre;

    assign tick = run && (pre == LAST);

    // Phase counter: cleared on start, frozen while paused, wraps on the tick cycle.
    always_ff @(posedge clk) begin
        if (!reset_n)   pre <= '0;
        else if (clear) pre <= '0;
        else if (run)   pre <= (pre == LAST) ? '0 : pre + 1'b1;
    end
endmodule

// File: rtl/delay_timer.sv
// delay_timer: loads a period on start, counts it down while enabled, flags expiry.
// Define DELAY_TIMER_PRESCALE_EN to make one unit PRESCALE enabled cycles;
// otherwise one unit is one enabled cycle (simulation-speed build).
module delay_timer
    import delay_timer_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int PRESCALE = DEF_PRESCALE
) (
    input  logic          clk,
    input  logic          reset_n,
    delay_timer_if.slave  bus
);
    state_t           state, state_nxt;
    logic [WIDTH-1:0] count, count_nxt;
    logic             run;
    logic             tick;

    assign run = (state == COUNTING) && bus.enable_delay_counter;

`ifdef DELAY_TIMER_PRESCALE_EN
    delay_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (bus.start_delay_counter),
        .run     (run),
        .tick    (tick)
    );
`else
    // Every enabled cycle is a unit; PRESCALE only qualifies legality here (>=1 gives 1).
    localparam logic PRESCALE_OK = (PRESCALE >= 1);
    assign tick = PRESCALE_OK;
`endif

    // Next state/count: start wins over enable; the count stops at zero.
    always_comb begin
        state_nxt = state;
        count_nxt = count;
        if (bus.start_delay_counter) begin
            count_nxt = bus.delay_value;
            state_nxt = (bus.delay_value != '0) ? COUNTING : EXPIRED;
        end else if (run && tick) begin
            count_nxt = count - 1'b1;
            if (count == WIDTH'(1)) state_nxt = EXPIRED;
        end
    end

    // State, count and decoded flags all registered so outputs have no input paths.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state               <= IDLE;
            count               <= '0;
            bus.delay_done      <= 1'b0;
            bus.busy            <= 1'b0;
            bus.count_remaining <= '0;
        end else begin
            state               <= state_nxt;
            count               <= count_nxt;
            bus.delay_done      <= (state_nxt == EXPIRED);
            bus.busy            <= (state_nxt == COUNTING);
            bus.count_remaining <= count_nxt;
        end
    end
endmodule
